sips4_prog_loader: RTL and testbench

//   Writer side of the SIPS4 16-bit instruction memory. Receives a framed

---
 rtl/sips4_prog_loader.sv | 193 +++++++++++++++++++
 tb/tb_sips4_prog_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sips4_prog_loader.sv
// sips4_prog_loader
// Writer side of the SIPS4 16-bit instruction memory. Parses a framed byte
// stream (SYNC, N, {hi,lo} x N, CSUM), writes each word into program memory
// and releases the CPU only after a complete frame with a matching checksum.
// Every output is registered. Outputs and state are computed one cycle
// ahead in the combinational block and loaded by the state register block.

module sips4_prog_loader #(
  parameter int unsigned ADDR_W    = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_run,
  output logic              done,
  output logic              err
);

  // One extra bit so a full-depth frame can count to 2**ADDR_W without
  // wrapping; the N byte is widened to 9 bits so N=0 can map to the depth.
  localparam int unsigned      DEPTH   = 2 ** ADDR_W;
  localparam int unsigned      CNT_W   = ADDR_W + 1;
  localparam logic [8:0]       DEPTH_N = 9'(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CSUM,
    S_RUN
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        hi_byte, hi_nxt;
  logic [7:0]        csum, csum_nxt;
  logic [CNT_W-1:0]  word_idx, idx_nxt;
  logic [CNT_W-1:0]  word_total, total_nxt;

  logic              rx_ready_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [15:0]       wdata_nxt;
  logic              run_nxt;
  logic              done_nxt;
  logic              err_nxt;

  logic              take;
  logic              is_sync;
  logic [8:0]        n_words;
  logic              n_bad;

  assign take    = rx_valid && rx_ready;
  assign is_sync = (rx_data == SYNC_BYTE);

  // Decode the count byte: zero means a full-depth program, anything larger than the depth is rejected.
  always_comb begin
    n_words = (rx_data == 8'd0) ? DEPTH_N : {1'b0, rx_data};
    n_bad   = (n_words > DEPTH_N);
  end

  // Frame parser: next state, next datapath registers and next registered outputs.
  always_comb begin
    state_nxt = state;
    hi_nxt    = hi_byte;
    csum_nxt  = csum;
    idx_nxt   = word_idx;
    total_nxt = word_total;
    we_nxt    = 1'b0;
    addr_nxt  = imem_addr;
    wdata_nxt = imem_wdata;
    run_nxt   = cpu_run;
    done_nxt  = 1'b0;
    err_nxt   = err;

    case (state)
      S_IDLE: begin
        if (take && is_sync) begin
          state_nxt = S_COUNT;
          run_nxt   = 1'b0;
          err_nxt   = 1'b0;
          idx_nxt   = '0;
          csum_nxt  = '0;
        end
      end

      S_COUNT: begin
        if (take) begin
          if (n_bad) begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            total_nxt = n_words[CNT_W-1:0];
            state_nxt = S_HI;
          end
        end
      end

      S_HI: begin
        if (take) begin
          hi_nxt    = rx_data;
          csum_nxt  = csum + rx_data;
          state_nxt = S_LO;
        end
      end

      S_LO: begin
        if (take) begin
          csum_nxt  = csum + rx_data;
          we_nxt    = 1'b1;
          addr_nxt  = word_idx[ADDR_W-1:0];
          wdata_nxt = {hi_byte, rx_data};
          state_nxt = S_WRITE;
        end
      end

      S_WRITE: begin
        // The strobe is already on the outputs this cycle; just advance.
        idx_nxt   = word_idx + ONE;
        state_nxt = ((word_idx + ONE) == word_total) ? S_CSUM : S_HI;
      end

      S_CSUM: begin
        if (take) begin
          if (rx_data == csum) begin
            run_nxt   = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = S_RUN;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end

      S_RUN: begin
        if (take && is_sync) begin
          state_nxt = S_COUNT;
          run_nxt   = 1'b0;
          err_nxt   = 1'b0;
          idx_nxt   = '0;
          csum_nxt  = '0;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    rx_ready_nxt = (state_nxt != S_WRITE);
  end

  // State register: loads every registered output and internal register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      hi_byte    <= '0;
      csum       <= '0;
      word_idx   <= '0;
      word_total <= '0;
      rx_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_run    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      hi_byte    <= hi_nxt;
      csum       <= csum_nxt;
      word_idx   <= idx_nxt;
      word_total <= total_nxt;
      rx_ready   <= rx_ready_nxt;
      imem_we    <= we_nxt;
      imem_addr  <= addr_nxt;
      imem_wdata <= wdata_nxt;
      cpu_run    <= run_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sips4_prog_loader.sv
// tb_sips4_prog_loader
// Drives framed byte streams (directed scenarios then random frames) into
// the loader. Expected writes, memory image, flags and byte counts come
// from how each frame was built, not from any state tracking of the DUT.

module tb_sips4_prog_loader;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_run;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int takenBytes = 0;
  int sentBytes = 0;
  int doneCount = 0;
  bit holdValid = 1'b0;

  logic [19:0] gotWrites[$];
  logic [7:0]  preJunk[$];
  logic [7:0]  postJunk[$];
  logic [15:0] memDut[DEPTH] = '{default: 16'h0};
  logic [15:0] memExp[DEPTH] = '{default: 16'h0};
  logic [15:0] frameWords[DEPTH];

  sips4_prog_loader #(.ADDR_W(4), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .done       (done),
    .err        (err)
  );

  // 100 MHz-style free-running clock for simulation.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] junkByte();
    logic [7:0] j;
    do j = 8'($urandom); while (j == 8'hA5);
    return j;
  endfunction

  // Count bytes the DUT actually takes on each active edge.
  always @(posedge clk) begin
    if (rst_n && rx_valid && rx_ready) takenBytes++;
  end

  // Record writes and done pulses; rx_ready must be low exactly while the write strobe is up.
  always @(negedge clk) begin
    if (imem_we) begin
      gotWrites.push_back({imem_addr, imem_wdata});
      memDut[imem_addr] = imem_wdata;
    end
    if (done) doneCount++;
    checkOutput("ready_vs_we", 32'(rx_ready), 32'(!imem_we));
  end

  // Present one byte at a negedge and return at the negedge after it was taken.
  task automatic applyStimulus(input logic [7:0] b);
    int waitCycles = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && waitCycles < 8) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!rx_ready) checkOutput("ready_timeout", 32'(rx_ready), 32'd1);
    @(negedge clk);
    sentBytes++;
    if (!holdValid && $urandom_range(0, 3) == 0) begin
      rx_valid = 1'b0;
      rx_data  = 8'hA5;
      @(negedge clk);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    checkOutput({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    checkOutput({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    checkOutput({tag, "_imem_wdata"}, 32'(imem_wdata), 32'd0);
    checkOutput({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic checkMemory(input string tag);
    for (int i = 0; i < DEPTH; i++)
      checkOutput($sformatf("%s_mem%0d", tag, i), 32'(memDut[i]), 32'(memExp[i]));
  endtask

  // Send one frame (with optional junk around it) and check everything it should have caused.
  task automatic runFrame(input string tag, input logic [7:0] nByte, input bit badSum);
    int n;
    bit badN;
    logic [7:0] sum;
    logic [19:0] expW[$];
    int wBase, dBase, tBase, sBase;
    n     = (nByte == 8'd0) ? DEPTH : int'(nByte);
    badN  = (n > DEPTH);
    wBase = gotWrites.size();
    dBase = doneCount;
    tBase = takenBytes;
    sBase = sentBytes;
    sum   = 8'd0;
    while (preJunk.size() > 0) applyStimulus(preJunk.pop_front());
    applyStimulus(8'hA5);
    checkOutput({tag, "_err_after_sync"}, 32'(err), 32'd0);
    checkOutput({tag, "_run_after_sync"}, 32'(cpu_run), 32'd0);
    applyStimulus(nByte);
    if (!badN) begin
      for (int i = 0; i < n; i++) begin
        applyStimulus(frameWords[i][15:8]);
        applyStimulus(frameWords[i][7:0]);
        sum = sum + frameWords[i][15:8] + frameWords[i][7:0];
        expW.push_back({4'(i), frameWords[i]});
        memExp[i] = frameWords[i];
      end
      applyStimulus(badSum ? (sum ^ 8'($urandom_range(1, 255))) : sum);
    end
    while (postJunk.size() > 0) applyStimulus(postJunk.pop_front());
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput({tag, "_cpu_run"}, 32'(cpu_run), 32'(!badN && !badSum));
    checkOutput({tag, "_err"}, 32'(err), 32'(badN || badSum));
    checkOutput({tag, "_done_pulses"}, 32'(doneCount - dBase), 32'(!badN && !badSum));
    checkOutput({tag, "_bytes_taken"}, 32'(takenBytes - tBase), 32'(sentBytes - sBase));
    checkOutput({tag, "_write_count"}, 32'(gotWrites.size() - wBase), 32'(expW.size()));
    for (int i = 0; i < expW.size(); i++)
      if (wBase + i < gotWrites.size())
        checkOutput($sformatf("%s_write%0d", tag, i), 32'(gotWrites[wBase + i]), 32'(expW[i]));
    checkMemory(tag);
  endtask

  // Abort a frame with reset after its first hi byte.
  task automatic resetMidFrame();
    int wBase, tBase, sBase;
    wBase = gotWrites.size();
    tBase = takenBytes;
    sBase = sentBytes;
    applyStimulus(8'hA5);
    applyStimulus(8'd3);
    applyStimulus(8'h5A);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    checkResetValues("midreset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midreset_no_write", 32'(gotWrites.size() - wBase), 32'd0);
    checkOutput("midreset_bytes_taken", 32'(takenBytes - tBase), 32'(sentBytes - sBase));
    checkMemory("midreset");
  endtask

  task automatic randomWords();
    for (int i = 0; i < DEPTH; i++) frameWords[i] = 16'($urandom);
  endtask

  // Time limit so a stuck DUT still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by random frames.
  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    @(negedge clk);

    frameWords[0] = 16'h1234;
    frameWords[1] = 16'hABCD;
    runFrame("t1_good", 8'd2, 1'b0);
    runFrame("t2_badsum", 8'd2, 1'b1);
    runFrame("t2_recover", 8'd2, 1'b0);

    for (int i = 0; i < DEPTH; i++) frameWords[i] = {8'(i), 8'(i)};
    runFrame("t3_full", 8'd0, 1'b0);

    postJunk = '{8'h12, 8'h34, 8'h56, 8'h78};
    runFrame("t4_badcount", 8'h11, 1'b0);

    holdValid = 1'b1;
    preJunk   = '{8'h00, 8'hFF};
    randomWords();
    runFrame("t5_junk", 8'd5, 1'b0);
    holdValid = 1'b0;

    resetMidFrame();
    randomWords();
    runFrame("t6_after_reset", 8'd0, 1'b0);

    for (int f = 0; f < 25; f++) begin
      logic [7:0] nb;
      holdValid = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) preJunk.push_back(junkByte());
      repeat ($urandom_range(0, 2)) postJunk.push_back(junkByte());
      if ($urandom_range(0, 9) < 7) nb = 8'($urandom_range(0, 16));
      else nb = 8'($urandom_range(17, 255));
      randomWords();
      runFrame($sformatf("rnd%0d", f), nb, ($urandom_range(0, 3) == 0));
    end
    holdValid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
